// File: rtl/mac4_pkg.sv
// Shared types and constants for the mac4_acc dot-product stage.
package mac4_pkg;
  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam int ACC_W_DEF   = 16;
  localparam int N_TERMS_DEF = 4;
  localparam int PROD_W      = 8;
endpackage

// File: rtl/arraymul4.sv
// Combinational 4x4 unsigned array multiplier: sum of shifted AND partial-product rows.
module arraymul4
  import mac4_pkg::*;
(
  input  logic [3:0]        a,
  input  logic [3:0]        b,
  output logic [PROD_W-1:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) begin
      p = p + ({4'b0000, a & {4{b[i]}}} << i);
    end
  end
endmodule

// File: rtl/mac4_acc.sv
// Pipelined multiply-accumulate: registers each 4x4 product, sums N_TERMS of them,
// then holds the result on a valid/ready output until consumed.
module mac4_acc
  import mac4_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int N_TERMS = N_TERMS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             overflow
);
  // Handshake: a beat moves on a rising edge where valid & ready are both high;
  // ready never depends combinationally on the same-cycle valid of the other side.
  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   p_q, p_d;
  logic                p_v_q, p_v_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [PROD_W-1:0]   prod;
  logic [ACC_W:0]      sum_ext;
  logic                xfer;

  arraymul4 u_mul (
    .a (a),
    .b (b),
    .p (prod)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    p_v_d   = 1'b0;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    xfer    = in_valid && (state_q == ACC);
    sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, p_q};

    if (xfer) begin
      p_d   = prod;
      p_v_d = 1'b1;
    end

    // Carry out of the top bit marks this result as overflowed until handoff.
    if (p_v_q) begin
      acc_d = sum_ext[ACC_W-1:0];
      if (sum_ext[ACC_W]) ovf_d = 1'b1;
    end

    case (state_q)
      ACC: begin
        if (xfer) begin
          if (cnt_q == CNT_W'(N_TERMS - 1)) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: state_d = OUT;
      OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase

    if (clear) begin
      state_d = ACC;
      cnt_d   = '0;
      p_v_d   = 1'b0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      cnt_q   <= '0;
      p_q     <= '0;
      p_v_q   <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      p_v_q   <= p_v_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign out_sum   = acc_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_mac4_acc.sv
// Bench for mac4_acc: two instances (ACC_W=16 and ACC_W=8) on shared stimulus,
// checked every cycle against a transaction-level dot-product model.
module tb_mac4_acc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  a = '0;
  logic [3:0]  b = '0;
  logic        out_ready = 1'b0;

  logic        in_ready16, out_valid16, overflow16;
  logic [15:0] out_sum16;
  logic        in_ready8, out_valid8, overflow8;
  logic [7:0]  out_sum8;

  int checks = 0;
  int failures = 0;

  // Model: true (unbounded) sum of products landed in the accumulator this result,
  // the product in flight, terms taken, and where the result is in its lifecycle.
  int m_total;
  int m_pend;
  int m_n;
  bit m_drain;
  bit m_hold;

  always #5 clk = ~clk;

  mac4_acc #(.ACC_W(16), .N_TERMS(4)) dut16 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .out_valid(out_valid16), .out_ready(out_ready),
    .out_sum(out_sum16), .overflow(overflow16)
  );

  mac4_acc #(.ACC_W(8), .N_TERMS(4)) dut8 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .out_valid(out_valid8), .out_ready(out_ready),
    .out_sum(out_sum8), .overflow(overflow8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_total = 0;
    m_pend  = -1;
    m_n     = 0;
    m_drain = 0;
    m_hold  = 0;
  endtask

  task automatic model_edge(input bit iv, input logic [3:0] av, input logic [3:0] bv,
                            input bit ordy, input bit clr);
    bit took;
    if (clr) begin
      model_reset();
      return;
    end
    took = iv && !m_drain && !m_hold;
    if (m_pend >= 0) m_total += m_pend;
    m_pend = took ? int'(av) * int'(bv) : -1;
    if (m_hold && ordy) begin
      m_total = 0;
      m_hold  = 0;
    end
    if (m_drain) begin
      m_drain = 0;
      m_hold  = 1;
    end
    if (took) begin
      m_n++;
      if (m_n == 4) begin
        m_n     = 0;
        m_drain = 1;
      end
    end
  endtask

  task automatic compare_all();
    bit exp_rdy;
    exp_rdy = !m_drain && !m_hold;
    chk("in_ready16",  32'(in_ready16),  32'(exp_rdy));
    chk("out_valid16", 32'(out_valid16), 32'(m_hold));
    chk("out_sum16",   32'(out_sum16),   32'(m_total % 65536));
    chk("overflow16",  32'(overflow16),  32'(m_total >= 65536));
    chk("in_ready8",   32'(in_ready8),   32'(exp_rdy));
    chk("out_valid8",  32'(out_valid8),  32'(m_hold));
    chk("out_sum8",    32'(out_sum8),    32'(m_total % 256));
    chk("overflow8",   32'(overflow8),   32'(m_total >= 256));
  endtask

  task automatic step(input bit iv, input logic [3:0] av, input logic [3:0] bv,
                      input bit ordy, input bit clr);
    in_valid  = iv;
    a         = av;
    b         = bv;
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    model_edge(iv, av, bv, ordy, clr);
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] ta [4];
    logic [3:0] tb [4];
    ta = '{4'd3, 4'd15, 4'd0, 4'd7};
    tb = '{4'd5, 4'd15, 4'd9, 4'd2};

    // Clock/reset
    model_reset();
    #2;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();

    // Full-rate burst, consumer always ready
    for (int i = 0; i < 4; i++) step(1, ta[i], tb[i], 1, 0);
    step(0, 0, 0, 1, 0);
    chk("burst_valid", 32'(out_valid16), 32'd1);
    chk("burst_sum",   32'(out_sum16),   32'd254);
    step(0, 0, 0, 1, 0);
    chk("burst_ready_back", 32'(in_ready16), 32'd1);

    // Backpressure with in_valid held high through DRAIN/OUT
    for (int i = 0; i < 4; i++) step(1, ta[i], tb[i], 0, 0);
    for (int i = 0; i < 4; i++) step(1, 4'd1, 4'd1, 0, 0);
    chk("bp_sum_held", 32'(out_sum16), 32'd254);
    step(1, 4'd1, 4'd1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 4'd2, 4'd2, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("bp_next_sum", 32'(out_sum16), 32'd16);
    step(0, 0, 0, 1, 0);

    // Gapped input
    for (int i = 0; i < 4; i++) begin
      step(1, 4'd2, 4'd3, 1, 0);
      if (i < 3) repeat (2) step(0, 4'd9, 4'd9, 1, 0);
    end
    step(0, 0, 0, 0, 0);
    chk("gap_sum", 32'(out_sum16), 32'd24);
    step(0, 0, 0, 1, 0);

    // Overflow in the narrow instance, then a clean result
    for (int i = 0; i < 4; i++) step(1, 4'd15, 4'd15, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("ovf8_sum",  32'(out_sum8),  32'd132);
    chk("ovf8_flag", 32'(overflow8), 32'd1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 4'd1, 4'd1, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("ovf8_next_sum",  32'(out_sum8),  32'd4);
    chk("ovf8_next_flag", 32'(overflow8), 32'd0);
    step(0, 0, 0, 1, 0);

    // clear mid-burst (with a transfer on the same edge), then clear while in OUT
    for (int i = 0; i < 2; i++) step(1, 4'd15, 4'd15, 1, 0);
    step(1, 4'd15, 4'd15, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 4'd1, 4'd2, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("clr_sum", 32'(out_sum16), 32'd8);
    step(0, 0, 0, 0, 1);
    chk("clr_out_valid", 32'(out_valid16), 32'd0);
    chk("clr_in_ready",  32'(in_ready16),  32'd1);

    // Asynchronous reset while in DRAIN
    for (int i = 0; i < 4; i++) step(1, 4'd7, 4'd7, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_sum",   32'(out_sum16),   32'd0);
    chk("rst_valid", 32'(out_valid16), 32'd0);
    chk("rst_ready", 32'(in_ready16),  32'd1);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 4'd4, 4'd4, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_next_sum", 32'(out_sum16), 32'd64);
    step(0, 0, 0, 1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac4_acc.md
# mac4_acc

Sequential multiply-accumulate stage that sits directly downstream of the 4x4 array multiplier. It accepts a stream of 4-bit operand pairs over a valid/ready handshake and registers each 8-bit product. It sums N_TERMS products into an accumulator, then presents the dot-product result on a second valid/ready handshake. It turns the combinational multiplier into a pipelined dot-product engine for the datapath.

## Interface
- ACC_W, default 16: accumulator/result width; must be ≥ 8.
- N_TERMS, default 4: products per result; must be ≥ 1.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- clear  in  1  synchronous abort; discards the partial sum.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the operand pair.
- a  in  4  unsigned multiplicand.
- b  in  4  unsigned multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  accumulated result.
- overflow  out  1  sticky; a carry left bit ACC_W-1 during this result.

## Operation
- States:
  - ACC: accepting operands.
  - DRAIN: the last product is in the product register.
  - OUT: holding the result.
- in_ready = (state==ACC); the value is decoded combinationally from state.
- A transfer is in_valid & in_ready at a rising edge.
- On a transfer, the product register p_q ← a*b (8 bits, from the multiplier core) and p_v ← 1. Otherwise p_v ← 0.
- Every edge with p_v=1: acc ← (acc + zero-extended p_q) mod 2^ACC_W. If the true sum is ≥ 2^ACC_W, overflow ← 1.
- term count cnt increments on each transfer.
- On the transfer that makes cnt = N_TERMS: state ACC→DRAIN and cnt ← 0.
- DRAIN→OUT unconditionally on the next edge; acc then includes the final product.
- In OUT: out_valid=1, out_sum=acc, overflow is valid.
  - out_sum and overflow stay stable while out_ready=0.
  - On out_valid & out_ready: acc ← 0, overflow ← 0, state → ACC.
- out_valid=0 in ACC and DRAIN. out_sum always shows acc.
- Operand inputs are ignored when in_ready=0. No input is accepted in DRAIN or OUT, including the edge where OUT completes its handoff.
- clear: highest priority below rst. It zeroes acc, cnt, p_v and overflow, sets state ACC, and drops any pending output. An input transfer on the same edge is discarded.
- rst: asynchronous. It zeroes acc, cnt, p_q, p_v and overflow, and sets state ACC.
  - Outputs during and after reset: out_valid=0, out_sum=0, overflow=0, in_ready=1.
  - Reset mid-operation discards all partial state.

## Timing
- Throughput: one operand pair per cycle in ACC, with no bubbles required.
- Latency:
  - Nth transfer at edge E → out_valid=1 after edge E+1.
  - Earliest next transfer is at edge E+3 if out_ready=1 at E+2, i.e. N_TERMS+2 cycles per result at full rate.
- Gaps in in_valid stall only the count; the accumulator holds the value.
- Product register to accumulator: one stage. There is no combinational path from a or b to any output.
- out_ready has no combinational effect on in_ready.

## Structure
- Package mac4_pkg holds:
  - the state enum (ACC, DRAIN, OUT);
  - default ACC_W and N_TERMS constants;
  - a PROD_W = 8 constant.
- One sub-module: the existing arraymul4 4x4 array multiplier, instantiated combinationally in front of p_q.
- FSM, counter, product register and accumulator live in mac4_acc.

## Test plan
- Full-rate pass, defaults: pairs (3,5),(15,15),(0,9),(7,2) on consecutive edges 1–4 with out_ready=1 → out_valid high for exactly one cycle after edge 5, out_sum=254, overflow=0, in_ready back to 1 after edge 6.
- Backpressure: same stimulus, out_ready=0 for 3 cycles → out_sum=254 held stable, in_ready=0 with in_valid=1 held, no transfer counted; release → handoff, next burst sums independently.
- Gapped input: 4 pairs of (2,3) with in_valid idle 2 cycles between each → out_sum=24, out_valid 1 cycle after the 4th transfer.
- Overflow, ACC_W=8: four (15,15) pairs → out_sum=132 (900 mod 256), overflow=1; next result (1,1)×4 → 4, overflow=0.
- clear after 2 transfers of (15,15), then (1,2)×4 → out_sum=8; clear asserted while in OUT → out_valid drops next edge, in_ready=1.
- rst asserted asynchronously mid-DRAIN → out_sum=0, out_valid=0, in_ready=1 immediately; next burst (4,4)×4 → 64.
